mem_arbiter2: RTL
=================

MEM_ARBITER2 -- requirements
Module: mem_arbiter2

Interface
REQ-001 SHALL have parameter BURST_BITS, default 2, log2 of read burst length returned by the slave (burst = 4 words).
REQ-002 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-003 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have, for each master k in {0,1}, port mk_waitrequest  output  1  command not accepted this cycle.
REQ-006 SHALL have mk_id  input  2  requester tag (non-zero when reading); mk_address  input  ADDR_W; mk_read  input  1; mk_write  input  1.
REQ-007 SHALL have mk_writedata  input  32; mk_writedatamask  input  4  byte enables.
REQ-008 SHALL have mk_readdata  output  32  (broadcast of s_readdata) and mk_readdataid  output  2  (0 = no data for master k).
REQ-009 SHALL have slave ports s_waitrequest  input  1; s_id  output  2; s_address  output  ADDR_W; s_read, s_write  output  1; s_writedata  output  32; s_writedatamask  output  4; s_readdata  input  32; s_readdataid  input  2.

Function
REQ-010 SHALL forward exactly one master's command to the slave per cycle, chosen combinationally; the unchosen master sees mk_waitrequest=1.
REQ-011 SHALL drive mk_waitrequest = s_waitrequest | !(grant==k) for a requesting master; an idle master sees s_waitrequest.
REQ-012 SHALL arbitrate round-robin: when both request with s_waitrequest=0, grant the master not recorded in last_grant; single requester always wins.
REQ-013 SHALL update last_grant only on an accepted command (request & !s_waitrequest).
REQ-014 SHALL drive s_read=s_write=0 and s_address/s_writedata/s_id from master 0 when no master requests.
REQ-015 SHALL keep FSM states IDLE and BURST; IDLE->BURST on accepted read, loading beat counter with 2^BURST_BITS and burst_owner with granted master.
REQ-016 SHALL in BURST decrement the counter on each cycle s_readdataid!=0; return to IDLE when counter reaches 0 (simultaneous new accepted read reloads counter and stays BURST).
REQ-017 SHALL route s_readdataid to mk_readdataid only for k==burst_owner, 0 to the other master, in the same cycle (zero added latency).
REQ-018 SHALL accept writes in either state; a write never changes burst_owner or counter.
REQ-019 SHALL not grant a new read while in BURST with counter>1 (holds requester with waitrequest=1), preventing burst interleave.
REQ-020 SHALL count with width BURST_BITS+1; counter never wraps below 0 (beats with counter 0 ignored and flagged by simulation assertion).
REQ-021 SHALL treat simultaneous mk_read & mk_write from one master as a write plus assertion failure.

Reset
REQ-022 SHALL on rst asynchronously set state=IDLE, counter=0, burst_owner=0, last_grant=1 (master 0 wins first tie).
REQ-023 SHALL force mk_readdataid=0 for both masters while rst=1; reset mid-burst drops remaining beats.
REQ-024 SHALL have s_read=s_write=0 during reset.

Structure
REQ-025 SHALL place BURST_BITS default, state encoding (IDLE=0, BURST=1) and ID-zero constant in shared package mem_arb_pkg.
REQ-026 SHALL be a single module; the round-robin pick is a natural sub-module rr_pick2 (req[1:0], last -> grant).

Verification
REQ-027 SHALL test: m0 read 0x100 alone, s_waitrequest=0 -> s_read=1, s_address=0x100, 4 beats routed to m0_readdataid, m1_readdataid=0.
REQ-028 SHALL test: m0 and m1 read same cycle after reset -> m0 granted first, m1 held until burst drains, then granted; last_grant=1.
REQ-029 SHALL test: m1 write 0xDEADBEEF mask 0xF during m0 burst -> write forwarded, m0 still receives all 4 beats.
REQ-030 SHALL test: continuous requests from both, 8 accepts -> grants alternate 0,1,0,1,...
REQ-031 SHALL test: rst asserted after 2 of 4 beats -> state IDLE, both readdataid 0 immediately, next read accepted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the two-master memory arbiter.
package mem_arb_pkg;

    localparam int BURST_BITS_DEF = 2;
    localparam logic [1:0] ID_ZERO = 2'd0;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the master not granted last time wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o
);

    always_comb begin
        grant_o = req_i[1];
        if (req_i == 2'b11) begin
            grant_o = ~last_i;
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master memory arbiter with read-burst ownership tracking so that
// returning read beats are routed to the master that issued the read.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int BURST_BITS = BURST_BITS_DEF,
    parameter int ADDR_W     = 30
) (
    input  logic              clock,
    input  logic              rst,

    output logic              m0_waitrequest,
    input  logic [1:0]        m0_id,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    input  logic [3:0]        m0_writedatamask,
    output logic [31:0]       m0_readdata,
    output logic [1:0]        m0_readdataid,

    output logic              m1_waitrequest,
    input  logic [1:0]        m1_id,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    input  logic [3:0]        m1_writedatamask,
    output logic [31:0]       m1_readdata,
    output logic [1:0]        m1_readdataid,

    input  logic              s_waitrequest,
    output logic [1:0]        s_id,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [31:0]       s_writedata,
    output logic [3:0]        s_writedatamask,
    input  logic [31:0]       s_readdata,
    input  logic [1:0]        s_readdataid
);

    localparam logic [BURST_BITS:0] CNT_ZERO  = '0;
    localparam logic [BURST_BITS:0] CNT_ONE   = {{BURST_BITS{1'b0}}, 1'b1};
    localparam logic [BURST_BITS:0] BURST_LEN = {1'b1, {BURST_BITS{1'b0}}};

    state_e              state_q, state_d;
    logic [BURST_BITS:0] cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;

    logic       rd0, rd1, wr0, wr1;
    logic       read_blk;
    logic [1:0] elig;
    logic       grant;
    logic       accept, acc_rd, beat;

    // A simultaneous read+write is demoted to a plain write.
    assign wr0 = m0_write;
    assign wr1 = m1_write;
    assign rd0 = m0_read & ~m0_write;
    assign rd1 = m1_read & ~m1_write;

    // New reads wait until only the final beat of the open burst is owed.
    assign read_blk = (state_q == BURST) && (cnt_q > CNT_ONE);

    assign elig[0] = wr0 | (rd0 & ~read_blk);
    assign elig[1] = wr1 | (rd1 & ~read_blk);

    rr_pick2 u_pick (
        .req_i   (elig),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign s_read  = ~rst & elig[grant] & (grant ? rd1 : rd0);
    assign s_write = ~rst & elig[grant] & (grant ? wr1 : wr0);

    assign s_address       = grant ? m1_address       : m0_address;
    assign s_id            = grant ? m1_id            : m0_id;
    assign s_writedata     = grant ? m1_writedata     : m0_writedata;
    assign s_writedatamask = grant ? m1_writedatamask : m0_writedatamask;

    assign m0_waitrequest = s_waitrequest |
                            ((m0_read | m0_write) & ~(elig[0] & ~grant));
    assign m1_waitrequest = s_waitrequest |
                            ((m1_read | m1_write) & ~(elig[1] & grant));

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    assign m0_readdataid = (!rst && !owner_q) ? s_readdataid : ID_ZERO;
    assign m1_readdataid = (!rst &&  owner_q) ? s_readdataid : ID_ZERO;

    assign accept = (s_read | s_write) & ~s_waitrequest;
    assign acc_rd = s_read & ~s_waitrequest;
    assign beat   = (s_readdataid != ID_ZERO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (accept) begin
            last_d = grant;
        end
        if (beat && cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
            end
        end
        if (acc_rd) begin
            state_d = BURST;
            cnt_d   = BURST_LEN;
            owner_d = grant;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    a_no_stray_beat : assert property (@(posedge clock) disable iff (rst)
        !(beat && cnt_q == CNT_ZERO));
    a_m0_rd_wr : assert property (@(posedge clock) disable iff (rst)
        !(m0_read && m0_write));
    a_m1_rd_wr : assert property (@(posedge clock) disable iff (rst)
        !(m1_read && m1_write));

endmodule
